// File: rtl/debug_reg_link.sv
// debug_reg_link
//   Debug-side initiator for the register file debug port. Decodes host
//   commands arriving as a byte stream from the debug UART receiver, holds
//   the CPU in reset, reads/writes architectural registers through the
//   debug port and streams the responses back to the UART transmitter.
//
// Parameters
//   TIMEOUT       inter-byte timeout (clk cycles) for a partial command
//   HOLD_ON_RESET debug_hold value during and after reset
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   rx_valid, rx_data         received byte strobe (no backpressure)
//   tx_valid, tx_data,
//   tx_ready                  response byte stream (valid/ready)
//   debug_hold                CPU reset / debug port ownership
//   debug_reg_oe/we           register read enable / write strobe
//   debug_reg_ra/rb           register index (rb mirrors ra)
//   debug_reg_data            write data
//   debug_reg_q               read data from register file port qa
//   rx_drop                   pulse when a byte is discarded while busy
module debug_reg_link #(
  parameter int TIMEOUT       = 100000,
  parameter bit HOLD_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        debug_hold,
  output logic        debug_reg_oe,
  output logic        debug_reg_we,
  output logic [4:0]  debug_reg_ra,
  output logic [4:0]  debug_reg_rb,
  output logic [31:0] debug_reg_data,
  input  logic [31:0] debug_reg_q,
  output logic        rx_drop
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_GET_IDX   = 4'd1;
  localparam logic [3:0] S_GET_DATA  = 4'd2;
  localparam logic [3:0] S_WR_SETUP  = 4'd3;
  localparam logic [3:0] S_WR_PULSE  = 4'd4;
  localparam logic [3:0] S_WR_HOLD   = 4'd5;
  localparam logic [3:0] S_RD_SETUP  = 4'd6;
  localparam logic [3:0] S_RD_SAMPLE = 4'd7;
  localparam logic [3:0] S_SEND      = 4'd8;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_HOLD  = 8'h48;
  localparam logic [7:0] OP_GO    = 8'h47;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  localparam int          TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  logic [3:0]    state;
  logic [TW-1:0] tmr;
  logic [1:0]    byte_cnt;
  logic          is_wr;
  logic [1:0]    tx_left;     // response bytes still queued behind tx_data
  logic          clr_pend;    // release the CPU once the ACK is accepted
  logic [7:0]    idx_q;
  logic [31:0]   dbuf;
  logic [23:0]   tx_shift;
  logic          busy;

  // Strobes decode straight from the state so an async reset drops them at once.
  assign debug_reg_we = (state == S_WR_PULSE);
  assign debug_reg_oe = (state == S_RD_SETUP) || (state == S_RD_SAMPLE);
  assign debug_reg_rb = debug_reg_ra;
  assign busy = !((state == S_IDLE) || (state == S_GET_IDX) || (state == S_GET_DATA));

  // Control FSM and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      tmr            <= '0;
      byte_cnt       <= '0;
      is_wr          <= 1'b0;
      tx_left        <= '0;
      clr_pend       <= 1'b0;
      tx_valid       <= 1'b0;
      tx_data        <= '0;
      debug_hold     <= HOLD_ON_RESET;
      debug_reg_ra   <= '0;
      debug_reg_data <= '0;
      rx_drop        <= 1'b0;
    end else begin
      rx_drop <= rx_valid && busy;
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            tmr      <= '0;
            byte_cnt <= '0;
            tx_left  <= '0;
            case (rx_data)
              OP_WRITE: begin is_wr <= 1'b1; state <= S_GET_IDX; end
              OP_READ:  begin is_wr <= 1'b0; state <= S_GET_IDX; end
              OP_HOLD: begin
                debug_hold <= 1'b1;
                tx_valid   <= 1'b1;
                tx_data    <= RSP_ACK;
                state      <= S_SEND;
              end
              OP_GO: begin
                clr_pend <= 1'b1;
                tx_valid <= 1'b1;
                tx_data  <= RSP_ACK;
                state    <= S_SEND;
              end
              default: begin
                tx_valid <= 1'b1;
                tx_data  <= RSP_NAK;
                state    <= S_SEND;
              end
            endcase
          end
        end
        S_GET_IDX: begin
          if (rx_valid) begin
            tmr <= '0;
            if (is_wr) begin
              state <= S_GET_DATA;
            end else if ((rx_data[7:5] == 3'd0) && debug_hold) begin
              debug_reg_ra <= rx_data[4:0];
              state        <= S_RD_SETUP;
            end else begin
              tx_valid <= 1'b1;
              tx_data  <= RSP_NAK;
              state    <= S_SEND;
            end
          end else if (tmr == TMR_LAST) begin
            state <= S_IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_GET_DATA: begin
          if (rx_valid) begin
            tmr      <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Bad commands are consumed in full before the NAK goes out.
              if ((idx_q[7:5] == 3'd0) && debug_hold) begin
                debug_reg_ra   <= idx_q[4:0];
                debug_reg_data <= {rx_data, dbuf[31:8]};
                state          <= S_WR_SETUP;
              end else begin
                tx_valid <= 1'b1;
                tx_data  <= RSP_NAK;
                state    <= S_SEND;
              end
            end
          end else if (tmr == TMR_LAST) begin
            state <= S_IDLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_WR_SETUP: state <= S_WR_PULSE;
        S_WR_PULSE: state <= S_WR_HOLD;
        S_WR_HOLD: begin
          tx_valid <= 1'b1;
          tx_data  <= RSP_ACK;
          state    <= S_SEND;
        end
        S_RD_SETUP: state <= S_RD_SAMPLE;
        S_RD_SAMPLE: begin
          tx_valid <= 1'b1;
          tx_data  <= debug_reg_q[7:0];
          tx_left  <= 2'd3;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (tx_valid && tx_ready) begin
            if (tx_left != 2'd0) begin
              tx_data <= tx_shift[7:0];
              tx_left <= tx_left - 2'd1;
            end else begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
              if (clr_pend) begin
                debug_hold <= 1'b0;
                clr_pend   <= 1'b0;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath holding registers (no reset needed; always loaded before use)
  always_ff @(posedge clk) begin
    if ((state == S_GET_IDX) && rx_valid) begin
      idx_q <= rx_data;
    end
    if ((state == S_GET_DATA) && rx_valid) begin
      dbuf <= {rx_data, dbuf[31:8]};
    end
    if (state == S_RD_SAMPLE) begin
      tx_shift <= debug_reg_q[31:8];
    end else if ((state == S_SEND) && tx_valid && tx_ready) begin
      tx_shift <= {8'd0, tx_shift[23:8]};
    end
  end

endmodule

// File: tb/tb_debug_reg_link.sv
// tb_debug_reg_link
//   Self-checking bench for debug_reg_link. A small register file model
//   answers the debug port; a command-level reference model predicts the
//   responses, register writes and debug_hold state.
module tb_debug_reg_link;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        debug_hold;
  logic        debug_reg_oe;
  logic        debug_reg_we;
  logic [4:0]  debug_reg_ra;
  logic [4:0]  debug_reg_rb;
  logic [31:0] debug_reg_data;
  logic [31:0] debug_reg_q;
  logic        rx_drop;

  always #5 clk = ~clk;

  debug_reg_link #(.TIMEOUT(TO), .HOLD_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .debug_hold(debug_hold), .debug_reg_oe(debug_reg_oe),
    .debug_reg_we(debug_reg_we), .debug_reg_ra(debug_reg_ra),
    .debug_reg_rb(debug_reg_rb), .debug_reg_data(debug_reg_data),
    .debug_reg_q(debug_reg_q), .rx_drop(rx_drop)
  );

  logic [31:0] rf    [32];   // register file seen by the DUT
  logic [31:0] mregs [32];   // reference model register contents
  logic        mhold;
  assign debug_reg_q = rf[debug_reg_ra];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Observation log, all maintained by tick()
  logic [7:0]  rsp_q[$];
  logic [7:0]  cmd_q[$];
  logic [7:0]  exp_q[$];
  int cyc = 0, last_cyc = 0, txr_cyc = -1, we_cyc = -1, oe_cyc = -1;
  int we_cnt = 0, oe_cnt = 0, drop_cnt = 0, stall = 0, rdy_mode = 0;
  logic [4:0]  we_ra;
  logic [31:0] we_data;
  logic pv = 1'b0, pr = 1'b0, poe = 1'b0;
  logic [7:0] pd = 8'd0;

  // Advance one cycle; drive tx_ready and record what the DUT does this cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = (($urandom % 2) == 1);
      default: begin
        if (!tx_valid) begin stall = 0; tx_ready = 1'b0; end
        else if (stall < 3) begin stall++; tx_ready = 1'b0; end
        else begin stall = 0; tx_ready = 1'b1; end
      end
    endcase
    if (rst) begin
      if (pv && !pr) begin
        chk("tx_stable_valid", {31'd0, tx_valid}, 32'd1);
        chk("tx_stable_data", {24'd0, tx_data}, {24'd0, pd});
      end
      if (tx_valid && !pv) txr_cyc = cyc;
      if (tx_valid && tx_ready) rsp_q.push_back(tx_data);
      if (debug_reg_we) begin
        we_cnt++; we_cyc = cyc; we_ra = debug_reg_ra; we_data = debug_reg_data;
        rf[debug_reg_ra] = debug_reg_data;
      end
      if (debug_reg_oe && !poe) oe_cyc = cyc;
      if (debug_reg_oe) oe_cnt++;
      if (debug_reg_oe || debug_reg_we) chk("rb_eq_ra", {27'd0, debug_reg_rb}, {27'd0, debug_reg_ra});
      if (rx_drop) drop_cnt++;
    end
    pv = tx_valid; pr = tx_ready; pd = tx_data; poe = debug_reg_oe;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    last_cyc = cyc;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic build_cmd(input logic [7:0] op, input logic [7:0] idx, input logic [31:0] d);
    cmd_q.delete();
    cmd_q.push_back(op);
    if (op == 8'h57 || op == 8'h52) cmd_q.push_back(idx);
    if (op == 8'h57) for (int k = 0; k < 4; k++) cmd_q.push_back(d[8*k +: 8]);
  endtask

  // Command-level reference model: predicts response bytes and port activity.
  task automatic model(output int ew, output int eo, output logic [4:0] era,
                       output logic [31:0] edata, output bit single, output bit good);
    logic [7:0] op, idx;
    logic [31:0] v;
    exp_q.delete();
    op = cmd_q[0]; ew = 0; eo = 0; single = 0; good = 0; era = '0; edata = '0;
    if (op == 8'h57) begin
      idx = cmd_q[1];
      edata = {cmd_q[5], cmd_q[4], cmd_q[3], cmd_q[2]};
      if (idx < 32 && mhold) begin
        good = 1; ew = 1; era = idx[4:0];
        mregs[idx[4:0]] = edata;
        exp_q.push_back(8'h06);
      end else exp_q.push_back(8'h15);
    end else if (op == 8'h52) begin
      idx = cmd_q[1];
      if (idx < 32 && mhold) begin
        good = 1; eo = 2;
        v = mregs[idx[4:0]];
        for (int k = 0; k < 4; k++) exp_q.push_back(v[8*k +: 8]);
      end else exp_q.push_back(8'h15);
    end else begin
      single = 1;
      if (op == 8'h48) begin mhold = 1'b1; exp_q.push_back(8'h06); end
      else if (op == 8'h47) begin mhold = 1'b0; exp_q.push_back(8'h06); end
      else exp_q.push_back(8'h15);
    end
  endtask

  task automatic run_cmd(input int gap_max, input int inject, input bit chk_lat);
    int ew, eo, r0, w0, o0, d0, g, n;
    logic [4:0] era;
    logic [31:0] edata;
    bit single, good;
    model(ew, eo, era, edata, single, good);
    r0 = rsp_q.size(); w0 = we_cnt; o0 = oe_cnt; d0 = drop_cnt;
    for (int i = 0; i < cmd_q.size(); i++) begin
      send_byte(cmd_q[i]);
      if (i != cmd_q.size() - 1) begin
        g = $urandom_range(0, gap_max);
        repeat (g) tick();
      end
    end
    n = last_cyc;
    if (inject > 0) begin
      g = 0;
      while (!tx_valid && g < 50) begin tick(); g++; end
      chk("drop_wait_tx", {31'd0, tx_valid}, 32'd1);
      for (int i = 0; i < inject; i++) send_byte(8'h48 + 8'(i));
    end
    g = 0;
    while ((rsp_q.size() - r0) < exp_q.size() && g < 400) begin tick(); g++; end
    chk("rsp_wait", {31'd0, (g < 400)}, 32'd1);
    repeat (8) tick();
    chk("rsp_len", 32'(rsp_q.size() - r0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (r0 + i < rsp_q.size()) chk("rsp_byte", {24'd0, rsp_q[r0+i]}, {24'd0, exp_q[i]});
    chk("we_count", 32'(we_cnt - w0), 32'(ew));
    if (ew == 1) begin
      chk("we_ra", {27'd0, we_ra}, {27'd0, era});
      chk("we_data", we_data, edata);
    end
    chk("oe_count", 32'(oe_cnt - o0), 32'(eo));
    chk("drop_count", 32'(drop_cnt - d0), 32'(inject));
    chk("hold", {31'd0, debug_hold}, {31'd0, mhold});
    if (chk_lat) begin
      if (single) chk("lat_single_tx", 32'(txr_cyc), 32'(n + 1));
      else if (good && ew == 1) begin
        chk("lat_wr_we", 32'(we_cyc), 32'(n + 2));
        chk("lat_wr_tx", 32'(txr_cyc), 32'(n + 4));
      end else if (good) begin
        chk("lat_rd_oe", 32'(oe_cyc), 32'(n + 1));
        chk("lat_rd_tx", 32'(txr_cyc), 32'(n + 3));
      end
    end
  endtask

  initial begin
    int r0, w0, sel;
    logic [7:0] op, idx;
    logic [31:0] keep;
    for (int i = 0; i < 32; i++) begin
      rf[i] = $urandom;
      mregs[i] = rf[i];
    end
    mhold = 1'b1;

    // Reset values
    repeat (3) tick();
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_oe", {31'd0, debug_reg_oe}, 32'd0);
    chk("rst_we", {31'd0, debug_reg_we}, 32'd0);
    chk("rst_ra", {27'd0, debug_reg_ra}, 32'd0);
    chk("rst_data", debug_reg_data, 32'd0);
    chk("rst_hold", {31'd0, debug_hold}, 32'd1);
    chk("rst_drop", {31'd0, rx_drop}, 32'd0);
    rst = 1'b1;
    repeat (4) tick();
    chk("idle_hold", {31'd0, debug_hold}, 32'd1);
    chk("idle_strobes", {30'd0, debug_reg_oe, debug_reg_we}, 32'd0);
    chk("idle_tx_valid", {31'd0, tx_valid}, 32'd0);

    // Directed commands
    rdy_mode = 0;
    build_cmd(8'h48, 8'h00, 32'h0);         run_cmd(0, 0, 1);
    build_cmd(8'h57, 8'h05, 32'hDEADBEEF);  run_cmd(0, 0, 1);
    rdy_mode = 2;
    build_cmd(8'h52, 8'h05, 32'h0);         run_cmd(0, 0, 1);
    rdy_mode = 0;
    build_cmd(8'h57, 8'h20, 32'h12345678);  run_cmd(0, 0, 1);
    build_cmd(8'h47, 8'h00, 32'h0);         run_cmd(0, 0, 1);
    build_cmd(8'h52, 8'h05, 32'h0);         run_cmd(0, 0, 1);
    build_cmd(8'h48, 8'h00, 32'h0);         run_cmd(0, 0, 1);
    build_cmd(8'hAA, 8'h00, 32'h0);         run_cmd(0, 0, 1);
    build_cmd(8'h57, 8'h00, 32'hCAFEF00D);  run_cmd(0, 0, 1);

    // Partial command abandoned by the inter-byte timeout
    r0 = rsp_q.size(); w0 = we_cnt;
    send_byte(8'h57); send_byte(8'h03); send_byte(8'h11);
    repeat (TO + 5) tick();
    chk("timeout_no_rsp", 32'(rsp_q.size() - r0), 32'd0);
    chk("timeout_no_we", 32'(we_cnt - w0), 32'd0);
    build_cmd(8'h48, 8'h00, 32'h0);         run_cmd(0, 0, 1);

    // Bytes arriving during a read response are dropped
    rdy_mode = 2;
    build_cmd(8'h52, 8'h05, 32'h0);         run_cmd(0, 3, 0);

    // Randomized command stream
    for (int t = 0; t < 60; t++) begin
      rdy_mode = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      idx = (($urandom % 8) == 0) ? 8'($urandom) : 8'($urandom % 32);
      case (sel)
        0, 1, 2, 3: op = 8'h57;
        4, 5, 6:    op = 8'h52;
        7:          op = 8'h48;
        8:          op = 8'h47;
        default:    op = 8'($urandom);
      endcase
      build_cmd(op, idx, $urandom);
      run_cmd(3, 0, 1);
    end

    // Reset asserted in the middle of the write pulse
    rdy_mode = 0;
    build_cmd(8'h48, 8'h00, 32'h0);         run_cmd(0, 0, 0);
    keep = mregs[7];
    send_byte(8'h57); send_byte(8'h07);
    for (int k = 0; k < 4; k++) send_byte(~keep[8*k +: 8]);
    @(posedge clk);
    #1;
    cyc++;
    chk("rstw_we_before", {31'd0, debug_reg_we}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstw_we_async", {31'd0, debug_reg_we}, 32'd0);
    chk("rstw_oe", {31'd0, debug_reg_oe}, 32'd0);
    chk("rstw_hold", {31'd0, debug_hold}, 32'd1);
    pv = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    w0 = we_cnt;
    repeat (10) tick();
    chk("rstw_no_we", 32'(we_cnt - w0), 32'd0);
    chk("rstw_reg_kept", rf[7], keep);
    chk("rstw_tx_idle", {31'd0, tx_valid}, 32'd0);
    mhold = 1'b1;
    build_cmd(8'h52, 8'h07, 32'h0);         run_cmd(0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
